// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle control path.
package ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode to instruction-class decoder.
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class
);

    // Map major opcode to class; SYSTEM and anything unknown are illegal.
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OPC_LUI:    op_class = CLS_LUI;
            OPC_AUIPC:  op_class = CLS_AUIPC;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_JALR:   op_class = CLS_JALR;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_OP_IMM: op_class = CLS_ALU;
            OPC_OP:     op_class = CLS_ALU;
            default:    op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing.
module mc_control
    import ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 reg_write,
    output logic                 pc_write,
    output logic                 isBranch,
    output logic                 isJump,
    output logic                 isJALR,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    state_t               state_q;
    state_t               state_d;
    op_class_t            cls_q;
    op_class_t            cls_c;
    logic [INSTRET_W-1:0] instret_q;

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (cls_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_BOOT;
        else     state_q <= state_d;
    end

    // Capture the instruction class when leaving DECODE; later states ignore live opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cls_q <= CLS_ILLEGAL;
        else if (state_q == S_DECODE) cls_q <= cls_c;
    end

    // Retired-instruction counter, one tick per PC update, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           instret_q <= '0;
        else if (pc_write) instret_q <= instret_q + INSTRET_W'(1);
    end

    assign instret = instret_q;

    // Next-state and output decode; ir_write is the only input-dependent output.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        isBranch  = 1'b0;
        isJump    = 1'b0;
        isJALR    = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                if (imem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (cls_c == CLS_ILLEGAL) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (cls_q)
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        isBranch = 1'b1;
                        state_d  = S_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    default:             state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                isJump    = (cls_q == CLS_JAL);
                isJALR    = (cls_q == CLS_JALR);
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM for the RV32I core. It sequences the single shared datapath through fetch, decode, execute, memory and writeback. It generates the one-per-instruction `pc_write` strobe and the `isBranch`/`isJump`/`isJALR` selects consumed by the program counter. It also drives the instruction/data memory request handshakes and the register-file write enable.

## Interface
Parameters:
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; the single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  bits [6:0] of the instruction register; valid from DECODE onward.
- `imem_ready`  in  1  instruction memory completes the transfer this cycle.
- `dmem_ready`  in  1  data memory completes the transfer this cycle.
- `imem_req`  out  1  instruction fetch request.
- `ir_write`  out  1  load the instruction register.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data access is a store.
- `reg_write`  out  1  register-file write enable.
- `pc_write`  out  1  PC update strobe.
- `isBranch`, `isJump`, `isJALR`  out  1 each  PC source selects.
- `halted`  out  1  core stopped.
- `instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
- States: BOOT, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- BOOT: all outputs 0. Moves to FETCH unconditionally on the next edge.
- FETCH:
  - `imem_req`=1.
  - `ir_write` = `imem_ready` (Mealy).
  - Stays in FETCH while `imem_ready`=0, otherwise moves to DECODE.
- DECODE: no strobes asserted.
  - A legal opcode moves to EXECUTE.
  - Any other opcode moves to HALT; SYSTEM (1110011) also moves to HALT.
  - Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- EXECUTE:
  - BRANCH: `pc_write`=1 and `isBranch`=1, then FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 iff STORE.
  - Stays in MEM until `dmem_ready`.
  - On `dmem_ready`: a STORE asserts `pc_write` and goes to FETCH; a LOAD goes to WB.
- WB:
  - `reg_write`=1 and `pc_write`=1, then FETCH.
  - `isJump`=1 for JAL; `isJALR`=1 for JALR.
- HALT: absorbing; `halted`=1 and all strobes 0. Only `rst` exits HALT.
- `isBranch`/`isJump`/`isJALR` are 0 in every cycle where `pc_write`=0. At most one of them is 1.
- `instret` increments by 1 on each edge where `pc_write`=1. It wraps modulo 2^`INSTRET_W`.
- The opcode class is latched into a state register at the DECODE→EXECUTE edge. Later states use the latched class, not the live `opcode`.

## Timing
- Reset:
  - `rst`=1 forces BOOT immediately, asynchronously.
  - While in BOOT every output is 0, including `instret`=0.
  - Reset asserted mid-MEM or mid-FETCH drops `imem_req`/`dmem_req` in the same cycle.
- Cycles per instruction, with zero-wait memory and counting from the FETCH entry:
  - BRANCH: 3.
  - STORE: 4.
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - LOAD: 5.
- Each memory wait cycle adds 1 cycle.
- Request handshake:
  - A request is held high with no gaps until its ready signal arrives.
  - A transfer completes on the edge where req and ready are both 1.
  - A ready signal while the matching req is 0 is ignored.
- `pc_write` is high for exactly one cycle per retired instruction. It is never asserted in FETCH, DECODE, BOOT or HALT.
- All outputs are Moore outputs of the state and latched class. The sole exception is `ir_write`, which also depends on `imem_ready`.

## Structure
- Package `ctrl_pkg`:
  - `state_t` enum.
  - Opcode localparams.
  - `op_class_t` enum: ALU, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ILLEGAL.
- Sub-module `opcode_class`: combinational opcode → `op_class_t` mapping. It is reused by the testbench scoreboard.
- `mc_control` holds the state register, the latched class, the `instret` counter and the output decode.

## Test plan
- Reset release, then an OP (0110011) fetch with `imem_ready`=1 continuously:
  - BOOT → FETCH → DECODE → EXECUTE → WB.
  - `pc_write` and `reg_write` are high in cycle 4 after FETCH entry.
  - `instret`=1.
- BRANCH fetch:
  - `pc_write`=1 and `isBranch`=1 in EXECUTE only.
  - `reg_write` never asserted.
  - FETCH is re-entered on the next cycle.
- LOAD with `dmem_ready` delayed 3 cycles:
  - `dmem_req` held for 4 cycles with `dmem_we`=0.
  - WB follows with `reg_write`=1.
  - Total 8 cycles.
- JALR then JAL back-to-back:
  - `isJALR`=1 in the first WB and `isJump`=1 in the second WB, each alongside `pc_write`.
  - `instret` advances by 2.
- Opcode 0000000 in DECODE:
  - HALT on the next edge with `halted`=1.
  - No further `imem_req` for 20 cycles.
  - `rst` pulse returns to BOOT with `instret`=0.
- `rst` asserted during the MEM wait of a STORE:
  - `dmem_req` drops in the same cycle.
  - No `pc_write` occurs.
  - Restart fetches normally.
